// File: rtl/iob_mem_responder_pkg.sv
// rtl/iob_mem_responder_pkg.sv - shared constants for the IOb memory responder
package iob_mem_responder_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int NBYTES       = DEF_DATA_W / 8;
    localparam int NBYTES_W     = $clog2(NBYTES);
    localparam int MAX_READ_LAT = 8;

    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int calc_nbytes_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/iob_mem_responder_if.sv
// rtl/iob_mem_responder_if.sv - IOb request/response bus between cache back-end and memory
interface iob_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 24
) ();

    logic                  avalid_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [DATA_W/8-1:0]   wstrb_i;
    logic                  ready_o;
    logic                  rvalid_o;
    logic [DATA_W-1:0]     rdata_o;

    modport master (
        output avalid_i, addr_i, wdata_i, wstrb_i,
        input  ready_o, rvalid_o, rdata_o
    );

    modport slave (
        input  avalid_i, addr_i, wdata_i, wstrb_i,
        output ready_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/iob_mem_responder_ram.sv
// rtl/iob_mem_responder_ram.sv - single-port RAM, byte write enables, registered read
module iob_mem_responder_ram #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [MEM_ADDR_W-1:0] idx,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];

    // Contents are deliberately not reset so they survive a responder reset
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/iob_mem_responder.sv
// rtl/iob_mem_responder.sv - IOb memory responder with fixed read latency
// Optional feature: IOB_MEM_RESPONDER_STALL_EN adds LFSR-driven wait states on ready_o.
module iob_mem_responder
    import iob_mem_responder_pkg::*;
#(
    parameter int          DATA_W     = DEF_DATA_W,
    parameter int          ADDR_W     = 24,
    parameter int          MEM_ADDR_W = 10,
    parameter int          READ_LAT   = 2,
    parameter logic [15:0] STALL_SEED = LFSR_SEED
) (
    input  logic               clk_i,
    input  logic               rst_i,
    iob_mem_responder_if.slave bus
);

    localparam int BYTE_OFS_W = calc_nbytes_w(DATA_W);

    generate
        if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT || (DATA_W % 8) != 0) begin : g_bad_cfg
            $error("iob_mem_responder: READ_LAT must be 1..8 and DATA_W a multiple of 8");
        end
    endgenerate

    logic                  ready_q;
    logic                  acc;
    logic                  is_wr;
    logic                  rd_en;
    logic                  wr_en;
    logic                  ram_valid;
    logic [DATA_W-1:0]     ram_q;
    logic [MEM_ADDR_W-1:0] idx;
    logic                  unused_addr;

    // Gating with rst_i keeps the first reset cycle from accepting while ready_q drains
    assign acc   = bus.avalid_i & ready_q & ~rst_i;
    assign is_wr = |bus.wstrb_i;
    assign rd_en = acc & ~is_wr;
    assign wr_en = acc & is_wr;
    assign idx   = bus.addr_i[BYTE_OFS_W +: MEM_ADDR_W];
    assign unused_addr = ^bus.addr_i;

    assign bus.ready_o = ready_q;

`ifdef IOB_MEM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr    <= STALL_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr    <= lfsr_step(lfsr);
            ready_q <= ~(lfsr[1] & lfsr[0]);
        end
    end
`else
    logic [15:0] unused_seed;
    assign unused_seed = STALL_SEED;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end
`endif

    iob_mem_responder_ram #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .idx   (idx),
        .wstrb (bus.wstrb_i),
        .wdata (bus.wdata_i),
        .rdata (ram_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_valid <= 1'b0;
        end else begin
            ram_valid <= rd_en;
        end
    end

    // The RAM read register is stage one; each later stage loads only on valid so data holds
    generate
        if (READ_LAT == 1) begin : g_lat1
            assign bus.rvalid_o = ram_valid;
            assign bus.rdata_o  = ram_q;
        end else begin : g_dly
            logic [READ_LAT-1:1] v_q;
            logic [DATA_W-1:0]   d_q [1:READ_LAT-1];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v_q <= '0;
                    for (int i = 1; i < READ_LAT; i++) begin
                        d_q[i] <= '0;
                    end
                end else begin
                    v_q[1] <= ram_valid;
                    if (ram_valid) begin
                        d_q[1] <= ram_q;
                    end
                    for (int i = 2; i < READ_LAT; i++) begin
                        v_q[i] <= v_q[i-1];
                        if (v_q[i-1]) begin
                            d_q[i] <= d_q[i-1];
                        end
                    end
                end
            end

            assign bus.rvalid_o = v_q[READ_LAT-1];
            assign bus.rdata_o  = d_q[READ_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_iob_mem_responder.sv
// tb/tb_iob_mem_responder.sv - scoreboard bench for iob_mem_responder
module tb_iob_mem_responder;

`ifdef IOB_MEM_RESPONDER_STALL_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rv_count = 0;
    int   low_count = 0;
    bit   started = 1'b0;
    logic exp_ready = 1'b0;
    logic [15:0] m = 16'hACE1;
    logic [31:0] last_rd = '0;
    logic [31:0] mm [16];
    exp_t q [$];

    iob_mem_responder_if #(.DATA_W(32), .ADDR_W(24)) bus ();

    iob_mem_responder #(
        .DATA_W     (32),
        .ADDR_W     (24),
        .MEM_ADDR_W (4),
        .READ_LAT   (L),
        .STALL_SEED (16'hACE1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m         = 16'hACE1;
            exp_ready = 1'b0;
            last_rd   = '0;
        end else begin
`ifdef IOB_MEM_RESPONDER_STALL_EN
            exp_ready = ~(m[1] & m[0]);
            m         = step(m);
`else
            exp_ready = 1'b1;
`endif
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus.rvalid_o) begin
            rv_count++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexp_rvalid: got rvalid=1 want 0 (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("rdata", bus.rdata_o, e.d);
                check("rlat", cyc, e.c);
            end
            last_rd = bus.rdata_o;
        end else begin
            check("rdata_hold", bus.rdata_o, last_rd);
        end
        check("ready", {31'd0, bus.ready_o}, {31'd0, exp_ready});
        if (started && !rst && !bus.ready_o) low_count++;
    end

    task automatic req(input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input bit push, input logic [31:0] exp);
        bit got = 1'b0;
        exp_t e;
        bus.avalid_i = 1'b1;
        bus.addr_i   = a;
        bus.wdata_i  = wd;
        bus.wstrb_i  = ws;
        for (int w = 0; w < 64; w++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            if (push) begin
                e.d = exp;
                e.c = cyc + L;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end else begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 want 1 (addr %h)", a);
        end
        bus.avalid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 40 && q.size() != 0; w++) @(negedge clk);
        check("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_model(input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws);
        for (int b = 0; b < 4; b++) begin
            if (ws[b]) mm[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
        end
        req(a, wd, ws, 1'b0, '0);
    endtask

    initial begin
        int rv_snap;
        logic [23:0] a;
        logic [31:0] wd;
        logic [3:0]  ws;

        bus.avalid_i = 1'b1;
        bus.addr_i   = '0;
        bus.wdata_i  = '0;
        bus.wstrb_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.avalid_i = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'd0, bus.ready_o}, 32'd0);
        idle(2);

        req(24'h40, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        req(24'h40, 32'h00001234, 4'h3, 1'b0, '0);
        req(24'h40, '0, 4'h0, 1'b1, 32'hDEAD1234);
        drain();

        for (int k = 0; k < 4; k++) req(24'(k * 4), 32'(k + 1), 4'hF, 1'b0, '0);
        for (int k = 0; k < 4; k++) req(24'(k * 4), '0, 4'h0, 1'b1, 32'(k + 1));
        drain();

        req(24'h0, 32'h55, 4'hF, 1'b0, '0);
        req(24'h40, '0, 4'h0, 1'b1, 32'h55);
        drain();

        req(24'h14, 32'hCAFEF00D, 4'hF, 1'b0, '0);
        rv_snap = rv_count;
        req(24'h14, '0, 4'h0, 1'b0, '0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(8);
        check("flush_no_rvalid", rv_count, rv_snap);
        req(24'h14, '0, 4'h0, 1'b1, 32'hCAFEF00D);
        drain();

        for (int k = 0; k < 16; k++) wr_model(24'(k * 4), 32'hA5000000 | 32'(k * 32'h01010), 4'hF);
        for (int n = 0; n < 200; n++) begin
            a  = 24'($urandom);
            wd = $urandom;
            ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (ws == 4'h0) req(a, '0, 4'h0, 1'b1, mm[a[5:2]]);
            else wr_model(a, wd, ws);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

`ifdef IOB_MEM_RESPONDER_STALL_EN
        total++;
        if (low_count == 0) begin
            bad++;
            $display("FAIL stall_seen: got low_cycles=%0d want >0", low_count);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
